// File: rtl/overflow_pkg.sv
// Shared constants, operation encoding and the sign-bit overflow rule
// for the overflow detector slice.
package overflow_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_CNT_WIDTH = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Overflow occurs when the operands push the result sign the "wrong" way.
  // For subtraction, B's sign is effectively inverted before the comparison.
  function automatic logic ovf_detect(input logic sa, input logic sb,
                                      input logic sr, input logic op_sub);
    logic operand_signs_ok;
    if (op_e'(op_sub) == OP_SUB) operand_signs_ok = (sa != sb);
    else                         operand_signs_ok = (sa == sb);
    return operand_signs_ok && (sr != sa);
  endfunction

endpackage

// File: rtl/overflow_status_counter.sv
// Sticky overflow flag plus saturating event counter. A clear discards
// the old history but still records an event arriving on the same edge.
module overflow_status_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 ovf_event,
  output logic                 sticky,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (clr) begin
      sticky <= ovf_event;
      count  <= CNT_WIDTH'(ovf_event);
    end else if (ovf_event) begin
      sticky <= 1'b1;
      if (count != '1) count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/overflow_detector.sv
// Registered two's-complement overflow detector: judges overflow from the
// sign bits of A, B and the ALU result and keeps sticky/count status.
module overflow_detector
  import overflow_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 op_sub,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     result,
  input  logic                 clr_status,
  output logic                 out_valid,
  output logic                 overflow_flag,
  output logic                 sticky_overflow,
  output logic [CNT_WIDTH-1:0] overflow_count
);

  logic ovf_event;
  logic unused_low_bits;

  // Gating with in_valid keeps undriven operands from reaching any output.
  assign ovf_event = in_valid &&
                     ovf_detect(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1], op_sub);

  assign unused_low_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0], result[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      out_valid     <= in_valid;
      overflow_flag <= ovf_event;
    end
  end

  overflow_status_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_status (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_status),
    .ovf_event (ovf_event),
    .sticky    (sticky_overflow),
    .count     (overflow_count)
  );

endmodule

// File: tb/tb_overflow_detector.sv
// Directed and randomized checks of overflow_detector against a reference
// that judges overflow from the true signed arithmetic result range.
module tb_overflow_detector;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 op_sub;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     result;
  logic                 clr_status;
  logic                 out_valid;
  logic                 overflow_flag;
  logic                 sticky_overflow;
  logic [CNT_WIDTH-1:0] overflow_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  bit m_valid, m_flag, m_sticky;
  int m_count;

  overflow_detector #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .op_sub          (op_sub),
    .a               (a),
    .b               (b),
    .result          (result),
    .clr_status      (clr_status),
    .out_valid       (out_valid),
    .overflow_flag   (overflow_flag),
    .sticky_overflow (sticky_overflow),
    .overflow_count  (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // True signed result out of range, assuming result is the truncated sum.
  function automatic bit range_ovf(input bit sub, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int s  = sub ? sx - sy : sx + sy;
    return (s > 127) || (s < -128);
  endfunction

  // One clock: drive inputs, update reference at the edge, check after it.
  task automatic cycle(input string tag, input logic v, input logic sub,
                       input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic [WIDTH-1:0] xr, input logic clr,
                       input logic rst_i, input bit exp_ovf);
    bit hit;
    rst = rst_i; in_valid = v; op_sub = sub; a = xa; b = xb; result = xr;
    clr_status = clr;
    @(posedge clk);
    hit = (v === 1'b1) && exp_ovf;
    if (rst_i) begin
      m_valid = 0; m_flag = 0; m_sticky = 0; m_count = 0;
    end else begin
      m_valid = (v === 1'b1);
      m_flag  = hit;
      if (clr) begin
        m_sticky = hit;
        m_count  = hit ? 1 : 0;
      end else if (hit) begin
        m_sticky = 1;
        m_count  = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".flag"},      32'(overflow_flag), 32'(m_flag));
    chk({tag, ".sticky"},    32'(sticky_overflow), 32'(m_sticky));
    chk({tag, ".count"},     32'(overflow_count), 32'(m_count));
  endtask

  initial begin
    bit v, sub, clr;
    logic [WIDTH-1:0] ra, rb, rr;

    m_valid = 0; m_flag = 0; m_sticky = 0; m_count = 0;
    rst = 1; in_valid = 0; op_sub = 0; a = '0; b = '0; result = '0; clr_status = 0;
    @(posedge clk); #1;

    cycle("reset", 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);

    // directed adds: 100+50, 127+1, -100+-40, -50+20, 80+-90, -128+-1
    cycle("add_100_50",   1, 0, 8'd100, 8'd50,  8'h96, 0, 0, 1);
    cycle("add_127_1",    1, 0, 8'd127, 8'd1,   8'h80, 0, 0, 1);
    cycle("add_m100_m40", 1, 0, 8'h9C,  8'hD8,  8'h74, 0, 0, 1);
    cycle("add_m50_20",   1, 0, 8'hCE,  8'd20,  8'hE2, 0, 0, 0);
    cycle("add_80_m90",   1, 0, 8'd80,  8'hA6,  8'hF6, 0, 0, 0);
    cycle("add_m128_m1",  1, 0, 8'h80,  8'hFF,  8'h7F, 0, 0, 1);
    chk("after_adds.count", 32'(overflow_count), 32'd4);
    chk("after_adds.sticky", 32'(sticky_overflow), 32'd1);

    cycle("sub_m128_1", 1, 1, 8'h80, 8'd1, 8'h7F, 0, 0, 1);
    cycle("sub_5_3",    1, 1, 8'd5,  8'd3, 8'd2,  0, 0, 0);

    // sign-only rule: wrong results judged purely by their sign bit
    cycle("wrong_res_pos", 1, 0, 8'd1, 8'd1, 8'd5,  0, 0, 0);
    cycle("wrong_res_neg", 1, 0, 8'd1, 8'd1, 8'h80, 0, 0, 1);

    cycle("invalid_ovf_ops", 0, 0, 8'd100, 8'd50, 8'h96, 0, 0, 1);
    cycle("invalid_x_ops",   0, 1, 'x, 'x, 'x, 0, 0, 1);

    for (int i = 0; i < 300; i++)
      cycle("saturate", 1, 0, 8'd100, 8'd50, 8'h96, 0, 0, 1);
    chk("saturate.final", 32'(overflow_count), 32'd255);

    cycle("clr_with_ovf", 1, 0, 8'd127, 8'd1, 8'h80, 1, 0, 1);
    chk("clr_with_ovf.count", 32'(overflow_count), 32'd1);
    cycle("clr_alone", 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0);
    chk("clr_alone.count", 32'(overflow_count), 32'd0);

    for (int i = 0; i < 200; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      sub = $urandom_range(0, 1);
      clr = ($urandom_range(0, 15) == 0);
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rr  = sub ? ra - rb : ra + rb;
      cycle("random", v, sub, ra, rb, rr, clr, 0, range_ovf(sub, ra, rb));
    end

    cycle("pre_rst", 1, 0, 8'd100, 8'd50, 8'h96, 0, 0, 1);
    cycle("mid_rst", 1, 0, 8'd100, 8'd50, 8'h96, 1, 1, 1);
    cycle("post_rst_ovf", 1, 1, 8'h80, 8'd1, 8'h7F, 0, 0, 1);
    cycle("post_rst_ok",  1, 0, 8'd3,  8'd4, 8'd7,  0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/overflow_detector.md
Name: overflow_detector

Overview:
- Registered two's-complement overflow detector for a WIDTH-bit adder/subtractor datapath.
- Takes operands A and B plus the result the ALU already produced, and flags signed overflow from sign bits only. It does not recompute the sum.
- Keeps a sticky overflow flag and a saturating overflow-event counter for status/debug readout.
- Sits beside the ALU result register; consumers sample its outputs one cycle after the operation is presented.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- CNT_WIDTH, 8, width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B/result/op_sub are valid this cycle
- op_sub  input  1  0: result = A+B; 1: result = A-B
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- result  input  WIDTH  ALU result to check (truncated to WIDTH)
- clr_status  input  1  clears sticky flag and counter
- out_valid  output  1  registered copy of in_valid
- overflow_flag  output  1  overflow for the operation presented last cycle
- sticky_overflow  output  1  set by any overflow since reset/clear
- overflow_count  output  CNT_WIDTH  number of overflowing operations, saturating

Behaviour:
- Sign bits used: sa = a[WIDTH-1], sb = b[WIDTH-1], sr = result[WIDTH-1].
- Add (op_sub=0): ovf = (sa == sb) and (sr != sa).
- Sub (op_sub=1): ovf = (sa != sb) and (sr != sa).
- Only sign bits are inspected. The block never checks that result equals the true A op B; a wrong result with consistent signs is not flagged.
- Latency is one cycle. On a rising edge with in_valid=1: out_valid <= 1 and overflow_flag <= ovf.
- With in_valid=0: out_valid <= 0 and overflow_flag <= 0. The flag is never asserted without out_valid.
- Sticky flag: sticky_overflow <= 1 on any edge where in_valid=1 and ovf=1; otherwise it holds.
- Counter: overflow_count increments by 1 on each such edge. It saturates at all-ones, with no wrap.
- clr_status:
  - Clears sticky_overflow and overflow_count to 0 at the edge.
  - Does not affect out_valid or overflow_flag.
  - If a valid overflow arrives in the same cycle as clr_status, clear wins for the old history, then the new event is recorded: sticky=1, count=1.
- Reset (rst=1 at edge): out_valid, overflow_flag, sticky_overflow = 0; overflow_count = 0.
  - Reset has priority over everything, including in_valid and clr_status.
  - Reset applied mid-stream discards the in-flight result; out_valid is 0 on the cycle after reset.
- Inputs are not registered internally beyond the single output stage. There is no backpressure: one operation per cycle is accepted.
- X on a/b/result while in_valid=0 must not propagate to any output.

Decomposition:
- Shared package overflow_pkg holds:
  - the default WIDTH/CNT_WIDTH constants;
  - an op enum (OP_ADD=0, OP_SUB=1);
  - a pure function ovf_detect(sa, sb, sr, op_sub) returning the combinational flag.
- One natural sub-module: overflow_status_counter (sticky flag plus saturating counter with clear/increment priority). The top handles detection and the output register.

Test Plan:
- Add with in_valid=1, checking overflow_flag one cycle later with out_valid=1 in each case:
  - a=100, b=50, result=150 (0x96) -> 1
  - a=127, b=1, result=0x80 -> 1
  - a=0x9C (-100), b=0xD8 (-40), result=0x74 -> 1
  - a=0xCE (-50), b=20, result=0xE2 -> 0
  - a=80, b=0xA6 (-90), result=0xF6 -> 0
  - a=0x80 (-128), b=0xFF (-1), result=0x7F -> 1
  - After this sequence: sticky_overflow=1, overflow_count=4.
- Sub checks:
  - a=0x80, b=1, op_sub=1, result=0x7F -> overflow_flag=1.
  - a=5, b=3, op_sub=1, result=2 -> 0.
- in_valid=0 with overflowing operands (100, 50, 150) -> out_valid=0, overflow_flag=0, counter unchanged.
- Drive 300 consecutive overflowing adds with CNT_WIDTH=8 -> overflow_count stops at 255.
- clr_status=1 together with a valid overflow -> next cycle sticky=1, count=1. clr_status alone -> sticky=0, count=0.
- Assert rst mid-stream after overflows -> next cycle all outputs 0. First valid op after reset is reported normally.
